serial_tx8: RTL and testbench

SERIAL_TX8 -- requirements
Module: serial_tx8

---
 rtl/serial_tx8.sv | 94 +++++++++
 tb/tb_serial_tx8.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx8.sv
`timescale 1ns/1ps
// serial_tx8: parallel-in, serial-out byte transmitter (MSB first).
// Each bit is held for CLK_DIV clocks. bit_tick marks the last clock of each
// bit period so a far-end shift register can use it as its shift enable.
module serial_tx8 #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       sdo,
    output logic       bit_tick,
    output logic       busy,
    output logic       done
);

    // Divider must hold CLK_DIV-1 without wrapping; keep at least one bit.
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic             tick;

    // Outputs decode directly from state so reset forces them without a clock edge.
    assign tick      = (state_q == SHIFT) && (div_q == DIV_LAST);
    assign bit_tick  = tick;
    assign din_ready = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign sdo       = (state_q == SHIFT) ? shreg_q[7] : 1'b0;

    // Next-state, shift register and counter updates.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        div_d    = div_q;
        bitcnt_d = bitcnt_q;
        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    shreg_d  = din;
                    div_d    = '0;
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    div_d    = '0;
                    shreg_d  = {shreg_q[6:0], 1'b0};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = DONE;
                    end
                end else begin
                    div_d = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            div_q    <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            div_q    <= div_d;
            bitcnt_q <= bitcnt_d;
        end
    end

endmodule

// File: tb/tb_serial_tx8.sv
`timescale 1ns/1ps
// Bench for serial_tx8: a CLK_DIV=4 instance checked through a bit/byte
// scoreboard plus a far-end shift8 model, and a CLK_DIV=1 instance.
module tb_serial_tx8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] din4, din1;
    logic       vld4, vld1;
    logic       rdy4, sdo4, tick4, busy4, done4;
    logic       rdy1, sdo1, tick1, busy1, done1;

    serial_tx8 #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .din(din4), .din_valid(vld4), .din_ready(rdy4),
        .sdo(sdo4), .bit_tick(tick4), .busy(busy4), .done(done4)
    );

    serial_tx8 #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(vld1), .din_ready(rdy1),
        .sdo(sdo1), .bit_tick(tick1), .busy(busy1), .done(done1)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    logic       exp_bits[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] q4;

    typedef struct {
        logic [7:0] din;
        logic [7:0] noise;
        logic [7:0] seq;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] seq);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(seq[i]);
        exp_bytes.push_back(seq);
    endtask

    task automatic send4(input logic [7:0] b, input logic [7:0] seq);
        chk("ready_before_send", rdy4, 1);
        din4 = b;
        vld4 = 1'b1;
        push_byte(seq);
        step();
        vld4 = 1'b0;
    endtask

    task automatic wait_done4(input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            if (done4) seen = 1'b1;
            else step();
        end
        chk("done_within_bound", seen, 1);
        step();
    endtask

    // Far-end receiver: shifts sdo into Q[0] on every bit_tick.
    always @(posedge clk or negedge rst) begin
        if (!rst) q4 <= 8'h00;
        else if (tick4) q4 <= {q4[6:0], sdo4};
    end

    // Scoreboard: every tick consumes an expected bit, every done an expected byte.
    always @(negedge clk) begin
        if (rst) begin
            if (tick4) begin
                chk("tick_expected", exp_bits.size() != 0, 1);
                if (exp_bits.size() != 0) chk("sdo_at_tick", sdo4, exp_bits.pop_front());
            end
            if (done4) begin
                chk("done_expected", exp_bytes.size() != 0, 1);
                if (exp_bytes.size() != 0) chk("loopback_q", q4, exp_bytes.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        int ticks;
        int dn;

        tbl[0] = '{din: 8'h3C, noise: 8'hC3, seq: 8'b0011_1100};
        tbl[1] = '{din: 8'h00, noise: 8'hFF, seq: 8'b0000_0000};
        tbl[2] = '{din: 8'hFF, noise: 8'h00, seq: 8'b1111_1111};
        tbl[3] = '{din: 8'h01, noise: 8'h80, seq: 8'b0000_0001};
        tbl[4] = '{din: 8'h6B, noise: 8'h94, seq: 8'b0110_1011};

        rst  = 1'b0;
        din4 = 8'h00;
        din1 = 8'h00;
        vld4 = 1'b0;
        vld1 = 1'b0;
        #2;
        chk("rst_ready4", rdy4, 1);
        chk("rst_busy4", busy4, 0);
        chk("rst_sdo4", sdo4, 0);
        chk("rst_tick4", tick4, 0);
        chk("rst_done4", done4, 0);
        chk("rst_ready1", rdy1, 1);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Single byte A5 with per-cycle timing.
        v = 8'hA5;
        send4(v, 8'b1010_0101);
        for (int c = 1; c <= 32; c++) begin
            chk("a5_sdo", sdo4, v[7 - (c - 1) / 4]);
            chk("a5_tick", tick4, (c % 4) == 0);
            chk("a5_busy", busy4, 1);
            chk("a5_ready", rdy4, 0);
            step();
        end
        chk("a5_done", done4, 1);
        chk("a5_done_busy", busy4, 0);
        chk("a5_done_ready", rdy4, 0);
        chk("a5_done_sdo", sdo4, 0);
        step();
        chk("a5_idle_ready", rdy4, 1);
        chk("a5_idle_done", done4, 0);

        // Table: din is disturbed after acceptance; the byte in flight must not change.
        for (int k = 0; k < 5; k++) begin
            send4(tbl[k].din, tbl[k].seq);
            din4 = tbl[k].noise;
            wait_done4(40);
        end

        // Valid held high during a transfer is ignored until the first IDLE cycle.
        send4(8'h81, 8'b1000_0001);
        din4 = 8'hFF;
        vld4 = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            chk("ign_ready_low", rdy4, 0);
            if (c == 33) chk("ign_done", done4, 1);
            step();
        end
        chk("ign_ready_idle", rdy4, 1);
        push_byte(8'b1111_1111);
        step();
        vld4 = 1'b0;
        chk("ff_accepted", busy4, 1);
        wait_done4(40);

        // Reset after the third bit_tick of F0.
        send4(8'hF0, 8'b1111_0000);
        ticks = 0;
        for (int i = 0; i < 40 && ticks < 3; i++) begin
            if (tick4) ticks++;
            step();
        end
        chk("three_ticks_seen", ticks, 3);
        chk("sdo_before_rst", sdo4, 1);
        #3;
        rst = 1'b0;
        exp_bits.delete();
        exp_bytes.delete();
        #1;
        chk("midrst_sdo", sdo4, 0);
        chk("midrst_busy", busy4, 0);
        chk("midrst_ready", rdy4, 1);
        chk("midrst_tick", tick4, 0);
        #20;
        rst = 1'b1;
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            if (done4) dn++;
            step();
        end
        chk("no_done_after_rst", dn, 0);
        send4(8'h0F, 8'b0000_1111);
        wait_done4(40);

        // CLK_DIV=1 instance: one bit per clock.
        v = 8'b1001_0110;
        chk("d1_ready", rdy1, 1);
        din1 = 8'h96;
        vld1 = 1'b1;
        step();
        vld1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk("d1_sdo", sdo1, v[8 - c]);
            chk("d1_tick", tick1, 1);
            chk("d1_busy", busy1, 1);
            step();
        end
        chk("d1_done", done1, 1);
        chk("d1_done_busy", busy1, 0);
        step();
        chk("d1_idle_ready", rdy1, 1);

        chk("bit_queue_empty", exp_bits.size(), 0);
        chk("byte_queue_empty", exp_bytes.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
